// File: rtl/mem_stage.sv
// MEM stage: registers EX results, runs SRAM / memory-mapped UART load-store
// sequences and stalls upstream while a multi-cycle access is in flight.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | accepting requests; 1-cycle ops complete from here
//  RD        | SRAM read, ce_n/oe_n low, data sampled on exit
//  WR_SETUP  | SRAM write setup, ce_n low, bus driven
//  WR_PULSE  | SRAM write strobe, we_n low
//  WR_HOLD   | SRAM write hold, we_n high, bus still driven
//  UWR_WAIT  | waiting for UART transmitter to drain
//  UWR_PULSE | UART write strobe, wrn low, bus driven
//  URD1      | UART read strobe, first cycle
//  URD2      | UART read strobe, second cycle, byte sampled on exit
module mem_stage #(
    parameter int          RAM_AW         = 18,
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [15:0]       ex_alu_res,
    input  logic [15:0]       ex_wdata,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic [3:0]        ex_rd,
    output logic              stall,
    output logic              mem_valid,
    output logic              mem_reg_write,
    output logic [3:0]        mem_rd,
    output logic [15:0]       mem_wb_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_data_out,
    output logic              ram_data_oe,
    input  logic [15:0]       ram_data_in,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              uart_rdn,
    output logic              uart_wrn,
    input  logic              uart_data_ready,
    input  logic              uart_tbre,
    input  logic              uart_tsre
);

    typedef enum logic [3:0] {
        IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, UWR_WAIT, UWR_PULSE, URD1, URD2
    } state_t;

    state_t      state, state_nxt;
    logic        lat_reg_write;
    logic [3:0]  lat_rd;
    logic        is_stat, is_udata, tx_empty, done;

    assign is_stat  = (ex_alu_res == UART_STAT_ADDR);
    assign is_udata = (ex_alu_res == UART_DATA_ADDR);
    assign tx_empty = uart_tbre & uart_tsre;
    assign stall    = (state != IDLE);
    assign done     = (state == RD) || (state == WR_HOLD) ||
                      (state == UWR_PULSE) || (state == URD2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Strobes depend on the state register alone.
    always_comb begin
        state_nxt   = state;
        ram_ce_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_data_oe = 1'b0;
        uart_rdn    = 1'b1;
        uart_wrn    = 1'b1;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_mem_write) begin
                        if (is_udata)      state_nxt = UWR_WAIT;
                        else if (!is_stat) state_nxt = WR_SETUP;
                    end else if (ex_mem_read) begin
                        if (is_udata)      state_nxt = URD1;
                        else if (!is_stat) state_nxt = RD;
                    end
                end
            end
            RD: begin
                ram_ce_n  = 1'b0;
                ram_oe_n  = 1'b0;
                state_nxt = IDLE;
            end
            WR_SETUP: begin
                ram_ce_n    = 1'b0;
                ram_data_oe = 1'b1;
                state_nxt   = WR_PULSE;
            end
            WR_PULSE: begin
                ram_ce_n    = 1'b0;
                ram_we_n    = 1'b0;
                ram_data_oe = 1'b1;
                state_nxt   = WR_HOLD;
            end
            WR_HOLD: begin
                ram_ce_n    = 1'b0;
                ram_data_oe = 1'b1;
                state_nxt   = IDLE;
            end
            UWR_WAIT: begin
                if (tx_empty) state_nxt = UWR_PULSE;
            end
            UWR_PULSE: begin
                uart_wrn    = 1'b0;
                ram_data_oe = 1'b1;
                state_nxt   = IDLE;
            end
            URD1: begin
                uart_rdn  = 1'b0;
                state_nxt = URD2;
            end
            URD2: begin
                uart_rdn  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_rd        <= 4'd0;
            mem_wb_data   <= 16'd0;
            ram_addr      <= '0;
            ram_data_out  <= 16'd0;
            lat_reg_write <= 1'b0;
            lat_rd        <= 4'd0;
        end else begin
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            if (state == IDLE && ex_valid) begin
                ram_addr      <= RAM_AW'(ex_alu_res);
                ram_data_out  <= ex_wdata;
                lat_reg_write <= ex_reg_write & ~ex_mem_write;
                lat_rd        <= ex_rd;
                if (ex_mem_write) begin
                    // Store to the status register completes as a no-op.
                    if (is_stat) begin
                        mem_valid <= 1'b1;
                        mem_rd    <= ex_rd;
                    end
                end else if (ex_mem_read) begin
                    if (is_stat) begin
                        mem_valid     <= 1'b1;
                        mem_reg_write <= ex_reg_write;
                        mem_rd        <= ex_rd;
                        mem_wb_data   <= {14'd0, uart_data_ready, tx_empty};
                    end
                end else begin
                    mem_valid     <= 1'b1;
                    mem_reg_write <= ex_reg_write;
                    mem_rd        <= ex_rd;
                    mem_wb_data   <= ex_alu_res;
                end
            end
            if (done) begin
                mem_valid     <= 1'b1;
                mem_reg_write <= lat_reg_write;
                mem_rd        <= lat_rd;
            end
            if (state == RD)   mem_wb_data <= ram_data_in;
            if (state == URD2) mem_wb_data <= {8'h00, ram_data_in[7:0]};
        end
    end

endmodule
